// File: rtl/div_power2_pkg.sv
// ---------------------------------------------------------------------------
// | div_power2_pkg                                                          |
// | Shared widths and FSM encoding for the word-serial 2^k quotient engine. |
// | Revision: 1.0                                                           |
// ---------------------------------------------------------------------------
`default_nettype none

package div_power2_pkg;
  localparam int DATA_W = 1024;
  localparam int WORD_W = 32;
  localparam int EXP_W  = 11;
  localparam int NWORDS = DATA_W / WORD_W;
  localparam int CNT_W  = $clog2(NWORDS);
  localparam int SH_W   = $clog2(WORD_W);
  localparam int BOFS_W = EXP_W - SH_W;
  localparam int DIDX_W = $clog2(DATA_W);
  // Source word index j+b+1 reaches 95, so it needs two bits beyond the counter.
  localparam int WIDX_W = CNT_W + 2;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;
endpackage

`default_nettype wire

// File: rtl/div_power2_word_shift.sv
// ---------------------------------------------------------------------------
// | div_power2_word_shift                                                   |
// | Combinational 64->32 funnel shifter: res = ({hi, lo} >> r)[31:0].       |
// | Revision: 1.0                                                           |
// ---------------------------------------------------------------------------
`default_nettype none

module div_power2_word_shift
  import div_power2_pkg::*;
(
  input  logic [WORD_W-1:0] hi,
  input  logic [WORD_W-1:0] lo,
  input  logic [SH_W-1:0]   r,
  output logic [WORD_W-1:0] res
);

  logic [2*WORD_W-1:0] cat_sh;

  always_comb begin
    cat_sh = {hi, lo} >> r;
    res    = cat_sh[WORD_W-1:0];
  end

endmodule

`default_nettype wire

// File: rtl/div_power2_1024.sv
// ---------------------------------------------------------------------------
// | div_power2_1024                                                         |
// | Word-serial quotient oQ = iX >> iTwoexp, one 32-bit word per clock.     |
// | Optional round-half-up via `define DIV_POW2_ROUND_EN.                   |
// | Revision: 1.0                                                           |
// ---------------------------------------------------------------------------
`default_nettype none

module div_power2_1024
  import div_power2_pkg::*;
(
  input  logic              iClk,
  input  logic              iRst_n,
  input  logic              iStart,
  input  logic [DATA_W-1:0] iX,
  input  logic [EXP_W-1:0]  iTwoexp,
  input  logic              iAck,
  output logic              oBusy,
  output logic              oDataValid,
  output logic [DATA_W-1:0] oQ
);

  logic [1:0]                     state_q, state_d;
  logic [CNT_W-1:0]               cnt_q, cnt_d;
  logic [NWORDS-1:0][WORD_W-1:0]  x_q, x_d;
  logic [NWORDS-1:0][WORD_W-1:0]  q_q, q_d;
  logic [BOFS_W-1:0]              b_q, b_d;
  logic [SH_W-1:0]                r_q, r_d;

  logic [WIDX_W-1:0] lo_idx;
  logic [WIDX_W-1:0] hi_idx;
  logic [WORD_W-1:0] lo_word;
  logic [WORD_W-1:0] hi_word;
  logic [WORD_W-1:0] shifted;
  logic [WORD_W-1:0] word_res;
  logic              accept;

  assign accept = (state_q == ST_IDLE) && iStart;

  // Indices past the top word read as zero rather than wrapping.
  always_comb begin
    lo_idx  = WIDX_W'(cnt_q) + WIDX_W'(b_q);
    hi_idx  = lo_idx + WIDX_W'(1);
    lo_word = (lo_idx[WIDX_W-1:CNT_W] == '0) ? x_q[lo_idx[CNT_W-1:0]] : '0;
    hi_word = (hi_idx[WIDX_W-1:CNT_W] == '0) ? x_q[hi_idx[CNT_W-1:0]] : '0;
  end

  div_power2_word_shift u_word_shift (
    .hi  (hi_word),
    .lo  (lo_word),
    .r   (r_q),
    .res (shifted)
  );

`ifdef DIV_POW2_ROUND_EN
  logic              carry_q, carry_d;
  logic [WORD_W:0]   sum;
  logic [EXP_W-1:0]  k_m1;
  logic              rnd_bit;

  // The rounding bit X[k-1] enters as carry-in to word 0 and ripples upward one word per cycle.
  always_comb begin
    k_m1    = iTwoexp - EXP_W'(1);
    rnd_bit = 1'b0;
    if ((iTwoexp != '0) && (iTwoexp <= EXP_W'(DATA_W)))
      rnd_bit = iX[k_m1[DIDX_W-1:0]];
    sum     = {1'b0, shifted} + {{WORD_W{1'b0}}, carry_q};
    carry_d = carry_q;
    if (accept)
      carry_d = rnd_bit;
    else if (state_q == ST_SHIFT)
      carry_d = sum[WORD_W];
    word_res = sum[WORD_W-1:0];
  end

  always_ff @(posedge iClk) begin
    if (!iRst_n)
      carry_q <= 1'b0;
    else
      carry_q <= carry_d;
  end
`else
  assign word_res = shifted;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    x_d     = x_q;
    q_d     = q_q;
    b_d     = b_q;
    r_d     = r_q;
    case (state_q)
      ST_IDLE: begin
        if (iStart) begin
          x_d     = iX;
          b_d     = iTwoexp[EXP_W-1:SH_W];
          r_d     = iTwoexp[SH_W-1:0];
          q_d     = '0;
          cnt_d   = '0;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        q_d[cnt_q] = word_res;
        cnt_d      = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(NWORDS - 1))
          state_d = ST_DONE;
      end
      ST_DONE: begin
        if (iAck)
          state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge iClk) begin
    if (!iRst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      x_q     <= '0;
      q_q     <= '0;
      b_q     <= '0;
      r_q     <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      x_q     <= x_d;
      q_q     <= q_d;
      b_q     <= b_d;
      r_q     <= r_d;
    end
  end

  assign oBusy      = (state_q == ST_SHIFT);
  assign oDataValid = (state_q == ST_DONE);
  assign oQ         = oDataValid ? q_q : '0;

endmodule

`default_nettype wire
